// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: 4-stage Barrett reduction t = z mod q with valid/ready flow control.
// Optional macro BARRETT_ERR_EN adds out_err, which flags bad parameters or a result left unreduced.
module barrett_reduce_pipe #(
    parameter int W    = 64,
    parameter int MU_W = 65,
    parameter int K_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  z,
    input  logic [W-1:0]    q,
    input  logic [MU_W-1:0] mu,
    input  logic [K_W-1:0]  k,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef BARRETT_ERR_EN
    output logic            out_err,
`endif
    output logic [W-1:0]    t
);
    localparam int PW = 2*W + MU_W;
    logic            en;
    logic            v1, v2, v3;
    logic [W+1:0]    z1, z2;
    logic [W-1:0]    m1, m2, m3;
    logic [MU_W-1:0] mu1;
    logic [K_W-1:0]  k1;
    logic [2*W-1:0]  q1;
    logic [W+1:0]    q3, r3;
    logic [PW-1:0]   prod;
    logic [W+1:0]    qe, ra;
    logic [W-1:0]    rb;
`ifdef BARRETT_ERR_EN
    logic            b1, b2, b3;
`endif
    // One shared advance enable: the whole pipe moves unless the output is held.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    // Full-width quotient estimate product and the two final correction subtractions.
    always_comb begin
        prod = PW'(q1) * PW'(mu1);
        qe   = {2'b00, m3};
        ra   = (r3 >= qe) ? r3 - qe : r3;
        rb   = W'((ra >= qe) ? ra - qe : ra);
    end
    // Stage registers; only the low W+2 bits of z are needed since r is taken modulo 2^(W+2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            t         <= '0;
            z1        <= '0;
            z2        <= '0;
            m1        <= '0;
            m2        <= '0;
            m3        <= '0;
            mu1       <= '0;
            k1        <= '0;
            q1        <= '0;
            q3        <= '0;
            r3        <= '0;
`ifdef BARRETT_ERR_EN
            b1        <= 1'b0;
            b2        <= 1'b0;
            b3        <= 1'b0;
            out_err   <= 1'b0;
`endif
        end else if (en) begin
            v1        <= in_valid;
            z1        <= z[W+1:0];
            m1        <= q;
            mu1       <= mu;
            k1        <= k;
            q1        <= z >> (k - K_W'(1));
            v2        <= v1;
            z2        <= z1;
            m2        <= m1;
            q3        <= (W+2)'(prod >> (k1 + K_W'(1)));
            v3        <= v2;
            m3        <= m2;
            r3        <= z2 - q3 * {2'b00, m2};
            out_valid <= v3;
            t         <= rb;
`ifdef BARRETT_ERR_EN
            b1        <= (q == '0) || (k == '0) || (int'(k) > W);
            b2        <= b1;
            b3        <= b2;
            out_err   <= b3 || ({1'b0, ra} >= {qe, 1'b0});
`endif
        end
    end
endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb_barrett_reduce_pipe: scoreboard bench for barrett_reduce_pipe (out_err checked when BARRETT_ERR_EN is defined).
module tb_barrett_reduce_pipe;
    localparam int W = 64, MU_W = 65, K_W = 8;
    typedef struct {
        logic         dc;
        logic [W-1:0] v;
        logic         e;
        logic         lat;
        int           cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic [2*W-1:0]  z = '0;
    logic [W-1:0]    q = '0;
    logic [MU_W-1:0] mu = '0;
    logic [K_W-1:0]  k = '0;
    logic            in_ready, out_valid;
    logic [W-1:0]    t;
`ifdef BARRETT_ERR_EN
    logic            out_err;
`endif
    int              checks = 0, errors = 0, cyc = 0;
    logic            lat_on = 1'b1;
    exp_t            exp_q[$];
    exp_t            mon_e;
    logic            bad;

    barrett_reduce_pipe #(.W(W), .MU_W(MU_W), .K_W(K_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .z(z), .q(q), .mu(mu), .k(k), .out_valid(out_valid), .out_ready(out_ready),
`ifdef BARRETT_ERR_EN
        .out_err(out_err),
`endif
        .t(t)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [MU_W-1:0] calc_mu(input logic [W-1:0] qq, input logic [K_W-1:0] kk);
        logic [2*W:0] p;
        p = 1;
        p = p << (2 * int'(kk));
        return (qq == '0) ? '0 : MU_W'(p / {{(W+1){1'b0}}, qq});
    endfunction

    function automatic logic [W-1:0] ref_mod(input logic [2*W-1:0] zz, input logic [W-1:0] qq);
        return (qq == '0) ? '0 : W'(zz % {{W{1'b0}}, qq});
    endfunction

    // Scoreboard: pop and compare on output transfer, push the model result on input transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", W'(out_valid), W'(0));
            else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.dc) chk("t", t, mon_e.v);
                if (mon_e.lat) chk("latency", W'(cyc - mon_e.cyc), W'(4));
`ifdef BARRETT_ERR_EN
                chk("out_err", W'(out_err), W'(mon_e.e));
`endif
            end
        end
        if (rst_n && in_valid && in_ready) begin
            bad = (q == '0) || (k == '0) || (int'(k) > W);
            exp_q.push_back('{bad, ref_mod(z, q), bad, lat_on, cyc});
        end
    end

    task automatic send(input logic [2*W-1:0] zz, input logic [W-1:0] qq,
                        input logic [MU_W-1:0] mm, input logic [K_W-1:0] kk);
        z = zz; q = qq; mu = mm; k = kk; in_valid = 1'b1;
        @(negedge clk);
        for (int n = 0; !in_ready && n < 50; n++) @(negedge clk);
        if (!in_ready) begin
            errors++;
            $error("FAIL send_timeout: observed in_ready %0d expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; exp_q.size() != 0 && n < 200; n++) @(negedge clk);
        chk("drain_pending", W'(exp_q.size()), W'(0));
    endtask

    initial begin
        logic [W-1:0]   rq, t0;
        logic [2*W-1:0] rz;
        int             rk;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_t", t, W'(0));
        chk("reset_in_ready", W'(in_ready), W'(1));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk("post_reset_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;

        // Reference vector, then its result value checked against the literal.
        send(128'd365183773, 64'd768112, 65'd1431447, 8'd20);
        @(negedge clk);
        for (int n = 0; !out_valid && n < 10; n++) @(negedge clk);
        chk("ref_vector_t", t, W'(330573));
        drain();

        // Back-to-back z = 0, z = q, z = q^2-1.
        rz = 128'd768112 * 128'd768112 - 128'd1;
        send(128'd0, 64'd768112, 65'd1431447, 8'd20);
        send(128'd768112, 64'd768112, 65'd1431447, 8'd20);
        send(rz, 64'd768112, 65'd1431447, 8'd20);
        drain();

        // Boundaries: widest modulus and smallest.
        rq = '1;
        send({rq, rq} - 128'd1, rq, calc_mu(rq, 8'd64), 8'd64);
        send(128'd3, 64'd1, calc_mu(64'd1, 8'd1), 8'd1);
        send(128'd2, 64'd1, calc_mu(64'd1, 8'd1), 8'd1);
        // Random valid requests streamed back to back.
        for (int i = 0; i < 16; i++) begin
            rk = int'($urandom_range(1, 64));
            rq = {$urandom, $urandom};
            if (rk < 64) rq = rq & ((64'd1 << rk) - 64'd1);
            rq[rk-1] = 1'b1;
            rz = {$urandom, $urandom, $urandom, $urandom};
            if (rk < 64) rz = rz & ((128'd1 << (2*rk)) - 128'd1);
            send(rz, rq, calc_mu(rq, K_W'(rk)), K_W'(rk));
        end
        // Undefined request (q = 0) between valid ones must not disturb its neighbours.
        send(128'd1000, 64'd768112, 65'd1431447, 8'd20);
        send(128'd1000, 64'd0, 65'd0, 8'd20);
        send(128'd999999, 64'd768112, 65'd1431447, 8'd20);
        drain();

        // Stall: six requests with out_ready low for six cycles.
        lat_on = 1'b0;
        fork
            for (int i = 0; i < 6; i++)
                send(128'd500000000 + 128'(i * 7777), 64'd768112, 65'd1431447, 8'd20);
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                t0 = t;
                chk("stall_out_valid", W'(out_valid), W'(1));
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", W'(in_ready), W'(0));
                    chk("stall_hold_valid", W'(out_valid), W'(1));
                    chk("stall_hold_t", t, t0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        lat_on = 1'b1;

        // Asynchronous reset with three requests in flight.
        send(128'd123456789, 64'd768112, 65'd1431447, 8'd20);
        send(128'd987654321, 64'd768112, 65'd1431447, 8'd20);
        send(128'd555555555, 64'd768112, 65'd1431447, 8'd20);
        @(posedge clk); #2;
        chk("pre_reset_valid", W'(out_valid), W'(1));
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", W'(out_valid), W'(0));
        chk("async_reset_t", t, W'(0));
        chk("async_reset_in_ready", W'(in_ready), W'(1));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 chk("reset_hold_t", t, W'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(128'd42424242, 64'd768112, 65'd1431447, 8'd20);
        drain();

`ifdef BARRETT_ERR_EN
        send(128'd77, 64'd0, 65'd0, 8'd20);
        send(128'd365183773, 64'd768112, 65'd1431447, 8'd20);
        drain();
`endif
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/barrett_reduce_pipe.md
BARRETT_REDUCE_PIPE -- requirements
Module: barrett_reduce_pipe

Interface
REQ-001 SHALL have parameter W, default 64: modulus/result width in bits.
REQ-002 SHALL have parameter MU_W, default 65: width of precomputed mu.
REQ-003 SHALL have parameter K_W, default 8: width of shift exponent k.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  block accepts request this cycle.
REQ-008 z  input  2W  dividend.
REQ-009 q  input  W  modulus.
REQ-010 mu  input  MU_W  floor(2^(2k)/q).
REQ-011 k  input  K_W  bit length of q, 1..W.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 t  output  W  z mod q.

Function
REQ-015 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Pipeline SHALL be 4 registered stages sharing one advance enable en = !out_valid || out_ready; in_ready SHALL equal en.
REQ-017 S1: register z, q, k and q1 = z >> (k-1).
REQ-018 S2: register q3 = (q1 * mu) >> (k+1), full-width product, no truncation before shift.
REQ-019 S3: register r = z - q3*q, computed modulo 2^(W+2) (low W+2 bits only).
REQ-020 S4: apply up to two conditional subtractions (r >= q -> r - q), register as t.
REQ-021 Latency SHALL be exactly 4 cycles from input transfer to out_valid with no stall; throughput one result per cycle while out_ready is high.
REQ-022 Each stage SHALL carry a valid bit; bubbles SHALL propagate without producing out_valid.
REQ-023 While en is low, all stage registers and t SHALL hold; t SHALL not change while out_valid && !out_ready.
REQ-024 Results SHALL leave in input order; no request SHALL be dropped or duplicated.
REQ-025 For z < 2^(2k) and valid mu, t SHALL equal z mod q exactly; z = 0 -> 0; z = q -> 0.
REQ-026 Requests with z >= 2^(2k), q = 0, k = 0 or k > W give undefined t but SHALL not corrupt other in-flight requests.
REQ-027 Simultaneous input and output transfer in one cycle SHALL be supported at full rate.

Reset
REQ-028 On rst_n low, all stage valid bits and out_valid SHALL clear to 0 and t SHALL clear to 0 immediately, independent of clk.
REQ-029 Reset mid-operation SHALL discard all in-flight requests; first output after reset release SHALL come from a request accepted after release.
REQ-030 in_ready SHALL be 1 during and after reset (out_valid = 0).

Configuration
REQ-031 With macro BARRETT_ERR_EN defined, SHALL add output out_err (1 bit), valid with out_valid: set when q = 0, k = 0, k > W, or r >= q remains after two subtractions; out_err resets to 0 and holds under stall like t.
REQ-032 Without BARRETT_ERR_EN, port out_err SHALL not exist and no check logic SHALL be synthesised; functional behaviour otherwise identical.

Verification
REQ-033 z=365183773, q=768112, mu=1431447, k=20, out_ready=1 -> out_valid exactly 4 cycles later with t=330573.
REQ-034 Back-to-back z=0, z=768112, z=768112^2-1 (same q, mu, k) on consecutive cycles -> t=0, 0, 768111 on consecutive cycles, in order.
REQ-035 Stream 6 requests with out_ready held low from cycle 5 to 10 -> in_ready low while stalled, t/out_valid stable, all 6 results delivered in order after release.
REQ-036 Assert rst_n low with 3 requests in flight -> out_valid and t go 0 without a clock edge; no stale result after release.
REQ-037 With BARRETT_ERR_EN: q=0, k=20 -> out_err=1; the REQ-033 case -> out_err=0.
